// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared port indices, selector codes, header layout and helpers for the switch allocator
package arbitro_pkg;

    localparam int N_PORTS    = 5;

    localparam int P_CIMA     = 0;
    localparam int P_BAIXO    = 1;
    localparam int P_ESQUERDA = 2;
    localparam int P_DIREITA  = 3;
    localparam int P_CORE     = 4;

    localparam logic [2:0] SEL_CIMA     = 3'b000;
    localparam logic [2:0] SEL_BAIXO    = 3'b001;
    localparam logic [2:0] SEL_ESQUERDA = 3'b010;
    localparam logic [2:0] SEL_DIREITA  = 3'b011;
    localparam logic [2:0] SEL_CORE     = 3'b100;
    localparam logic [2:0] SEL_IDLE     = 3'b111;

    // Header layout, counted down from the flit MSB: dest X then dest Y.
    localparam int COORD_W            = 2;
    localparam int HDR_X_MSB_FROM_TOP = 0;
    localparam int HDR_Y_MSB_FROM_TOP = 2;
    localparam int HDR_BITS           = 2 * COORD_W;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } out_state_e;

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic logic [2:0] xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] pos_x,
        input logic [COORD_W-1:0] pos_y
    );
        if (dest_x > pos_x) begin
            return SEL_DIREITA;
        end else if (dest_x < pos_x) begin
            return SEL_ESQUERDA;
        end else if (dest_y > pos_y) begin
            return SEL_CIMA;
        end else if (dest_y < pos_y) begin
            return SEL_BAIXO;
        end else begin
            return SEL_CORE;
        end
    endfunction

    // (base + step) mod 5 for base, step in 0..4.
    function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [N_PORTS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (oh[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr5.sv
// rtl/arb_rr5.sv - 5-way arbiter; search starts at ptr and wraps 4 -> 0, one-hot grant
module arb_rr5
    import arbitro_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [2:0]         ptr,
    output logic [N_PORTS-1:0] gnt
);

    // With ptr tied to zero this is plain fixed priority, lowest index first.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = wrap5(ptr, 3'(k));
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_crossbar.sv
// rtl/arbitro_crossbar.sv - XY switch allocator for a 5x5 crossbar; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module arbitro_crossbar
    import arbitro_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int POS_X  = 0,
    parameter int POS_Y  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        in_valid,
    input  logic [DATA_W-1:0] cima_in,
    input  logic [DATA_W-1:0] baixo_in,
    input  logic [DATA_W-1:0] esquerda_in,
    input  logic [DATA_W-1:0] direita_in,
    input  logic [DATA_W-1:0] core_in,
    input  logic [4:0]        out_ready,
    output logic [2:0]        sel_cima,
    output logic [2:0]        sel_baixo,
    output logic [2:0]        sel_esquerda,
    output logic [2:0]        sel_direita,
    output logic [2:0]        sel_core,
    output logic [4:0]        pop,
    output logic [4:0]        out_valid
);

    localparam logic [COORD_W-1:0] MY_X = COORD_W'(POS_X);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(POS_Y);

    logic [DATA_W-1:0]  head      [N_PORTS];
    logic [2:0]         route     [N_PORTS];
    logic [N_PORTS-1:0] locked;
    logic [N_PORTS-1:0] req       [N_PORTS];
    logic [N_PORTS-1:0] gnt       [N_PORTS];
    logic [2:0]         arb_ptr   [N_PORTS];
    logic [2:0]         sel_vec   [N_PORTS];

    out_state_e         state_q   [N_PORTS];
    out_state_e         state_d   [N_PORTS];
    logic [2:0]         winner_q  [N_PORTS];
    logic [2:0]         winner_d  [N_PORTS];
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]         ptr_q     [N_PORTS];
    logic [2:0]         ptr_d     [N_PORTS];
`endif

    // Only the header is inspected; the payload passes through the crossbar untouched.
    logic unused_payload;
    assign unused_payload = ^{cima_in[DATA_W-HDR_BITS-1:0], baixo_in[DATA_W-HDR_BITS-1:0],
                              esquerda_in[DATA_W-HDR_BITS-1:0], direita_in[DATA_W-HDR_BITS-1:0],
                              core_in[DATA_W-HDR_BITS-1:0]};

    always_comb begin
        head[P_CIMA]     = cima_in;
        head[P_BAIXO]    = baixo_in;
        head[P_ESQUERDA] = esquerda_in;
        head[P_DIREITA]  = direita_in;
        head[P_CORE]     = core_in;
    end

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            route[i] = xy_route(head[i][DATA_W-1-HDR_X_MSB_FROM_TOP -: COORD_W],
                                head[i][DATA_W-1-HDR_Y_MSB_FROM_TOP -: COORD_W],
                                MY_X, MY_Y);
        end
    end

    // An input stays locked for as long as some output holds it as winner in XFER.
    always_comb begin
        locked = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == ST_XFER) begin
                locked[winner_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                req[o][i] = in_valid[i] && !locked[i] && (route[i] == 3'(o));
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
`ifdef ARB_ROUND_ROBIN_EN
        assign arb_ptr[o] = ptr_q[o];
`else
        assign arb_ptr[o] = 3'd0;
`endif
        arb_rr5 u_arb (
            .req (req[o]),
            .ptr (arb_ptr[o]),
            .gnt (gnt[o])
        );
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            state_d[o]  = state_q[o];
            winner_d[o] = winner_q[o];
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d[o]    = ptr_q[o];
`endif
            case (state_q[o])
                ST_ARB: begin
                    if ((|gnt[o]) && out_ready[o]) begin
                        state_d[o]  = ST_XFER;
                        winner_d[o] = onehot_idx(gnt[o]);
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_d[o]    = wrap5(onehot_idx(gnt[o]), 3'd1);
`endif
                    end
                end
                ST_XFER: begin
                    if (out_ready[o]) begin
                        state_d[o] = ST_ARB;
                    end
                end
                default: state_d[o] = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < N_PORTS; o++) begin
            if (rst) begin
                state_q[o]  <= ST_ARB;
                winner_q[o] <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_q[o]    <= '0;
`endif
            end else begin
                state_q[o]  <= state_d[o];
                winner_q[o] <= winner_d[o];
`ifdef ARB_ROUND_ROBIN_EN
                ptr_q[o]    <= ptr_d[o];
`endif
            end
        end
    end

    // Selectors and valids decode straight from the grant flops; pop is suppressed
    // under reset so a dropped transfer leaves its flit in the FIFO.
    always_comb begin
        out_valid = '0;
        pop       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            sel_vec[i] = SEL_IDLE;
        end
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == ST_XFER) begin
                out_valid[o]         = 1'b1;
                sel_vec[winner_q[o]] = 3'(o);
                if (out_ready[o] && !rst) begin
                    pop[winner_q[o]] = 1'b1;
                end
            end
        end
    end

    assign sel_cima     = sel_vec[P_CIMA];
    assign sel_baixo    = sel_vec[P_BAIXO];
    assign sel_esquerda = sel_vec[P_ESQUERDA];
    assign sel_direita  = sel_vec[P_DIREITA];
    assign sel_core     = sel_vec[P_CORE];

endmodule

// File: tb/tb_arbitro_crossbar.sv
// tb/tb_arbitro_crossbar.sv - scoreboard bench for arbitro_crossbar at router position (1,1)
module tb_arbitro_crossbar;

    localparam int DATA_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        in_valid = '0;
    logic [DATA_W-1:0] cima_in = '0, baixo_in = '0, esquerda_in = '0, direita_in = '0, core_in = '0;
    logic [4:0]        out_ready = '1;
    logic [2:0]        sel_cima, sel_baixo, sel_esquerda, sel_direita, sel_core;
    logic [4:0]        pop, out_valid;

    always #5 clk = ~clk;

    arbitro_crossbar #(.DATA_W(DATA_W), .POS_X(1), .POS_Y(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .cima_in(cima_in), .baixo_in(baixo_in), .esquerda_in(esquerda_in),
        .direita_in(direita_in), .core_in(core_in), .out_ready(out_ready),
        .sel_cima(sel_cima), .sel_baixo(sel_baixo), .sel_esquerda(sel_esquerda),
        .sel_direita(sel_direita), .sel_core(sel_core), .pop(pop), .out_valid(out_valid)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [14:0] sels;
        logic [4:0]  ov;
        logic [4:0]  pp;
    } obs_t;

    obs_t              exp_q  [$];
    string             name_q [$];
    logic [DATA_W-1:0] fifo   [5][$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc   = 0;
    logic [4:0]        pop_s = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) pop_s = pop;

    // Monitor: every cycle with a live output is checked against the next expectation.
    always @(negedge clk) begin
        obs_t  act;
        obs_t  e;
        string nm;
        act.cyc  = cyc;
        act.sels = {sel_core, sel_direita, sel_esquerda, sel_baixo, sel_cima};
        act.ov   = out_valid;
        act.pp   = pop;
        if (out_valid !== 5'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got cyc=%0d sels=%o ov=%b pop=%b, required no output",
                         act.cyc, act.sels, act.ov, act.pp);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got cyc=%0d sels=%o ov=%b pop=%b, required cyc=%0d sels=%o ov=%b pop=%b",
                             nm, act.cyc, act.sels, act.ov, act.pp, e.cyc, e.sels, e.ov, e.pp);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] flit(input int x, input int y, input int pl);
        return {x[1:0], y[1:0], pl[9:0]};
    endfunction

    function automatic logic [14:0] sel1(input int i, input logic [2:0] code);
        logic [14:0] s;
        s = '1;
        s[3*i +: 3] = code;
        return s;
    endfunction

    task automatic push_exp(input int c, input logic [14:0] s, input logic [4:0] ov,
                            input logic [4:0] pp, input string nm);
        obs_t e;
        e.cyc = c; e.sels = s; e.ov = ov; e.pp = pp;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive_heads();
        logic [DATA_W-1:0] h [5];
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = (fifo[i].size() > 0);
            h[i] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        cima_in = h[0]; baixo_in = h[1]; esquerda_in = h[2]; direita_in = h[3]; core_in = h[4];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (pop_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        drive_heads();
    endtask

    task automatic check_idle(input string nm);
        logic [14:0] s;
        @(negedge clk);
        s = {sel_core, sel_direita, sel_esquerda, sel_baixo, sel_cima};
        n_cmp++;
        if (s !== 15'h7fff || pop !== 5'b0 || out_valid !== 5'b0) begin
            n_bad++;
            $display("FAIL %s: got sels=%o pop=%b ov=%b, required sels=77777 pop=00000 ov=00000",
                     nm, s, pop, out_valid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) fifo[i].delete();
        drive_heads();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int base;
    int ord_tab [3] = '{1, 2, 4};
    int who;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");

        // Single flit cima -> direita, sent in the cycle after the request.
        do_reset();
        fifo[0].push_back(14'h2400);
        drive_heads();
        push_exp(cyc + 1, sel1(0, 3'b011), 5'b01000, 5'b00001, "s1_cima_to_direita");
        repeat (4) tick();
        check_idle("s1_back_to_idle");

        // Three inputs contend for core, six flits each.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            fifo[1].push_back(flit(1, 1, 16 + k));
            fifo[2].push_back(flit(1, 1, 32 + k));
            fifo[4].push_back(flit(1, 1, 48 + k));
        end
        drive_heads();
        base = cyc;
        for (int j = 0; j < 18; j++) begin
`ifdef ARB_ROUND_ROBIN_EN
            who = ord_tab[j % 3];
`else
            who = ord_tab[j / 6];
`endif
            push_exp(base + 1 + 2 * j, sel1(who, 3'b100), 5'b10000, 5'(1 << who), "s2_core_contention");
        end
        repeat (40) tick();
        check_idle("s2_drained");

        // Stall on direita for three cycles.
        do_reset();
        fifo[0].push_back(flit(2, 1, 5));
        drive_heads();
        base = cyc;
        for (int j = 1; j <= 3; j++) push_exp(base + j, sel1(0, 3'b011), 5'b01000, 5'b00000, "s3_stall_hold");
        push_exp(base + 4, sel1(0, 3'b011), 5'b01000, 5'b00001, "s3_stall_release");
        tick();
        out_ready = 5'b10111;
        tick();
        tick();
        tick();
        out_ready = 5'b11111;
        repeat (3) tick();
        check_idle("s3_back_to_idle");

        // All five inputs to five distinct outputs at once.
        do_reset();
        fifo[0].push_back(flit(2, 1, 1));
        fifo[1].push_back(flit(0, 1, 2));
        fifo[2].push_back(flit(1, 2, 3));
        fifo[3].push_back(flit(1, 0, 4));
        fifo[4].push_back(flit(1, 1, 5));
        drive_heads();
        push_exp(cyc + 1, {3'b100, 3'b001, 3'b000, 3'b010, 3'b011}, 5'b11111, 5'b11111, "s4_all_five");
        repeat (3) tick();
        check_idle("s4_back_to_idle");

        // Reset lands in the middle of a transfer; the flit is re-granted once.
        do_reset();
        fifo[0].push_back(flit(2, 1, 7));
        drive_heads();
        base = cyc;
        push_exp(base + 1, sel1(0, 3'b011), 5'b01000, 5'b00000, "s5_xfer_under_reset");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("s5_after_reset");
        n_cmp++;
        if (fifo[0].size() != 1) begin
            n_bad++;
            $display("FAIL s5_flit_kept: got fifo depth %0d, required 1", fifo[0].size());
        end
        push_exp(base + 3, sel1(0, 3'b011), 5'b01000, 5'b00001, "s5_regrant");
        repeat (5) tick();
        check_idle("s5_delivered_once");
        n_cmp++;
        if (fifo[0].size() != 0) begin
            n_bad++;
            $display("FAIL s5_fifo_emptied: got fifo depth %0d, required 0", fifo[0].size());
        end

        // Every input wants core while core is not ready: nothing may be granted.
        do_reset();
        for (int i = 0; i < 5; i++) fifo[i].push_back(flit(1, 1, 9 + i));
        out_ready = 5'b01111;
        drive_heads();
        for (int j = 0; j < 4; j++) begin
            tick();
            check_idle("s6_core_blocked");
        end
        do_reset();
        out_ready = 5'b11111;
        repeat (2) tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: got %0d pending, required 0 pending", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
